instr_fetch: RTL and testbench

Instruction fetch stage for the RV processor. Holds the program counter, issues one word read at a time to instruction memory over a valid/ready request and valid response channel, and presents the returned 32-bit instruction to decode. Decode drives Instr[31:7] into the immediate extender. The resulting ImmExt and the branch decision PCSrc return to this block, which computes the next PC (PC+4 or PC+ImmExt) when decode consumes the instruction.

---
 rtl/rv_pkg.sv | 15 +
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV core front end: datapath width, the NOP
// encoding and the fetch-stage state encoding.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory read at a
// time, holds the returned word for decode and computes the next PC on consume.
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    output logic            misaligned,
    output logic [XLEN-1:0] fetch_count
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            misaligned_q, misaligned_d;
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] next_pc;

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_target = pc_q + ImmExt;
    assign next_pc   = PCSrc ? pc_target : pc_plus4;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        misaligned_d  = misaligned_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            REQ: begin
                if (imem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    // A misaligned target is counted as consumed but never fetched.
                    if (next_pc[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                        state_d      = FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= REQ;
            pc_q          <= RESET_PC;
            instr_q       <= NOP;
            misaligned_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = (state_q == HOLD);
    assign Instr          = instr_q;
    assign PC             = pc_q;
    assign PCPlus4        = pc_plus4;
    assign misaligned     = misaligned_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: accepted requests push the expected word,
// consumes pop it and compare against what the stage presents to decode.
module tb_instr_fetch;
    import rv_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] RST_PC2 = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] ImmExt = '0;

    logic        imem_req_valid, instr_valid, misaligned;
    logic [31:0] imem_addr, Instr, PC, PCPlus4, fetch_count;
    logic        imem_req_valid2, instr_valid2, misaligned2;
    logic [31:0] imem_addr2, Instr2, PC2, PCPlus42, fetch_count2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_consumed = 0;
    logic [31:0] model_pc = RST_PC;
    int          model_count = 0;
    logic        model_fault = 1'b0;
    sb_t         sb[$];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .PCSrc(PCSrc), .ImmExt(ImmExt),
        .misaligned(misaligned), .fetch_count(fetch_count)
    );

    instr_fetch #(.RESET_PC(RST_PC2)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr2), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid2), .instr_ready(instr_ready),
        .Instr(Instr2), .PC(PC2), .PCPlus4(PCPlus42),
        .PCSrc(PCSrc), .ImmExt(ImmExt),
        .misaligned(misaligned2), .fetch_count(fetch_count2)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {~a[15:0], a[15:8], 8'h13};
    endfunction

    // One clock: scoreboard at the negedge, memory model response after the posedge.
    task automatic tick();
        logic        acc;
        logic        cons;
        logic [31:0] acc_addr;
        logic [31:0] nxt;
        sb_t         e;
        @(negedge clk);
        acc = 1'b0;
        cons = 1'b0;
        acc_addr = imem_addr;
        if (!rst) begin
            acc  = imem_req_valid && imem_req_ready;
            cons = instr_valid && instr_ready;
            if (acc) begin
                n_cmp++;
                if (imem_addr !== model_pc) begin
                    n_err++;
                    $display("FAIL req_addr: got %h want %h", imem_addr, model_pc);
                end
                e.pc = model_pc;
                e.instr = memfn(model_pc);
                sb.push_back(e);
            end
            if (cons) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL consume_without_request: pc %h", PC);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (Instr !== e.instr || PC !== e.pc || PCPlus4 !== e.pc + 32'd4) begin
                        n_err++;
                        $display("FAIL consume: got instr %h pc %h pc4 %h want instr %h pc %h pc4 %h",
                                 Instr, PC, PCPlus4, e.instr, e.pc, e.pc + 32'd4);
                    end
                end
                nxt = PCSrc ? model_pc + ImmExt : model_pc + 32'd4;
                model_count++;
                if (nxt[1:0] != 2'b00) model_fault = 1'b1;
                else model_pc = nxt;
                n_consumed++;
            end
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            model_pc = RST_PC;
            model_count = 0;
            model_fault = 1'b0;
        end
        #1;
        imem_rsp_valid = acc;
        imem_rdata = acc ? memfn(acc_addr) : 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        PCSrc = 1'b0;
        ImmExt = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_consume(input logic src, input logic [31:0] imm);
        int target;
        PCSrc = src;
        ImmExt = imm;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        target = n_consumed + 1;
        for (int i = 0; i < 20 && n_consumed < target; i++) tick();
        if (n_consumed < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL consume_timeout: consumed %0d want %0d", n_consumed, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== RST_PC ||
            PC !== RST_PC || Instr !== NOP || misaligned !== 1'b0 || fetch_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: rv %b iv %b addr %h pc %h instr %h mis %b cnt %0d want 1 0 %h %h %h 0 0",
                     imem_req_valid, instr_valid, imem_addr, PC, Instr, misaligned, fetch_count,
                     RST_PC, RST_PC, NOP);
        end
        n_cmp++;
        if (PC2 !== RST_PC2 || imem_addr2 !== RST_PC2) begin
            n_err++;
            $display("FAIL reset_pc_param: got %h/%h want %h", PC2, imem_addr2, RST_PC2);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL seq_cycle1_valid: got %b want 0", instr_valid);
        end
        tick();
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL seq_cycle2_valid: got %b want 0", instr_valid);
        end
        tick();
        n_cmp++;
        if (instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL seq_cycle3_valid: got %b want 1", instr_valid);
        end
        for (int k = 0; k < 3; k++) run_consume(1'b0, 32'h0);
        n_cmp++;
        if (fetch_count !== 32'd3 || imem_addr !== 32'h0000_000C || imem_req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL seq_after3: cnt %0d addr %h rv %b want 3 0000000c 1",
                     fetch_count, imem_addr, imem_req_valid);
        end
    endtask

    task automatic test_branch();
        do_reset();
        run_consume(1'b1, 32'h0000_0100);
        run_consume(1'b1, 32'hFFFF_FFF0);
        n_cmp++;
        if (imem_addr !== 32'h0000_00F0) begin
            n_err++;
            $display("FAIL branch_back: got %h want 000000f0", imem_addr);
        end
        run_consume(1'b1, 32'h0000_0010);
        run_consume(1'b1, 32'h0000_0800);
        n_cmp++;
        if (imem_addr !== 32'h0000_0900) begin
            n_err++;
            $display("FAIL branch_fwd: got %h want 00000900", imem_addr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
                n_err++;
                $display("FAIL req_stall[%0d]: rv %b addr %h want 1 %h", k, imem_req_valid, imem_addr, RST_PC);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            PCSrc = $urandom_range(0, 1);
            ImmExt = $urandom;
            n_cmp++;
            if (instr_valid !== 1'b1 || Instr !== memfn(RST_PC) || PC !== RST_PC || fetch_count !== 32'd0) begin
                n_err++;
                $display("FAIL hold_stall[%0d]: iv %b instr %h pc %h cnt %0d want 1 %h %h 0",
                         k, instr_valid, Instr, PC, fetch_count, memfn(RST_PC), RST_PC);
            end
            tick();
        end
        run_consume(1'b0, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'h0000_0004 || fetch_count !== 32'd1) begin
            n_err++;
            $display("FAIL hold_release: addr %h cnt %0d want 00000004 1", imem_addr, fetch_count);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        run_consume(1'b1, 32'h0000_0010);
        run_consume(1'b1, 32'h0000_0006);
        n_cmp++;
        if (misaligned !== 1'b1 || dut.state_q !== FAULT || PC !== 32'h0000_0010 || fetch_count !== 32'd2) begin
            n_err++;
            $display("FAIL misalign: mis %b state %0d pc %h cnt %0d want 1 %0d 00000010 2",
                     misaligned, dut.state_q, PC, fetch_count, FAULT);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b1) begin
                n_err++;
                $display("FAIL fault_quiet[%0d]: rv %b iv %b mis %b want 0 0 1",
                         k, imem_req_valid, instr_valid, misaligned);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        run_consume(1'b0, 32'h0);
        n_cmp++;
        if (imem_addr2 !== 32'h0000_0000 || imem_req_valid2 !== 1'b1 || misaligned2 !== 1'b0) begin
            n_err++;
            $display("FAIL wrap: addr %h rv %b mis %b want 00000000 1 0", imem_addr2, imem_req_valid2, misaligned2);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (Instr !== NOP || PC !== RST_PC || imem_req_valid !== 1'b1 ||
            instr_valid !== 1'b0 || imem_addr !== RST_PC) begin
            n_err++;
            $display("FAIL reset_in_wait: instr %h pc %h rv %b iv %b addr %h want %h %h 1 0 %h",
                     Instr, PC, imem_req_valid, instr_valid, imem_addr, NOP, RST_PC, RST_PC);
        end
        run_consume(1'b0, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'h0000_0004 || fetch_count !== 32'd1) begin
            n_err++;
            $display("FAIL reset_recover: addr %h cnt %0d want 00000004 1", imem_addr, fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_backpressure();
        test_misalign();
        test_wrap();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
